des_iterative_engine: RTL

Sequential, parametrised DES Feistel engine that reuses one round datapath (Expansion_Permutation, S1–S8, Permutation) over ROUNDS clock cycles with an on-the-fly key schedule and valid/ready handshakes on both sides. Supports encrypt and decrypt and a configurable round count. It operates on IP-permuted blocks and returns pre-FP blocks. IP/FP stay in the surrounding wrapper.

---
 rtl/des_iterative_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/des_iterative_engine.sv
// Iterative DES Feistel core: one shared round datapath, on-the-fly key schedule.
// Consumes IP-permuted blocks and returns pre-FP blocks; IP/FP live in the wrapper.
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   RUN   | one Feistel round per cycle, rnd_q = current round
//   DONE  | out_block valid, held until out_ready
module des_iterative_engine #(
    parameter int ROUNDS     = 16,
    parameter bit SWAP_FINAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in_block,
    input  logic [1:64] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_block,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] RND_LAST = CW'(ROUNDS);

    localparam int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                               63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int EXP [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int PRM [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                                2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    // Each S-box is 64 nibbles, entry (row*16+col) counted from the most significant nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic int shift_of(input int i);
        return (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    endfunction

    function automatic int shift_sum(input int n);
        int s = 0;
        for (int i = 1; i <= n; i++) s += shift_of(i);
        return s;
    endfunction

    localparam int DEC_ROT = shift_sum(ROUNDS) % 28;

    function automatic logic [1:28] rotl(input logic [1:28] x, input int n);
        logic [1:28] o;
        for (int i = 1; i <= 28; i++) o[i] = x[((i - 1 + n) % 28) + 1];
        return o;
    endfunction

    function automatic logic [1:28] key_step(input logic [1:28] x, input logic dec, input int amt);
        if (dec) return (amt == 1) ? rotl(x, 27) : rotl(x, 26);
        return (amt == 1) ? rotl(x, 1) : rotl(x, 2);
    endfunction

    function automatic logic [1:48] f_expand(input logic [1:32] x);
        logic [1:48] o;
        for (int i = 1; i <= 48; i++) o[i] = x[EXP[i-1]];
        return o;
    endfunction

    function automatic logic [1:32] f_perm(input logic [1:32] x);
        logic [1:32] o;
        for (int i = 1; i <= 32; i++) o[i] = x[PRM[i-1]];
        return o;
    endfunction

    function automatic logic [1:32] f_sbox(input logic [1:48] x);
        logic [1:32] o;
        logic [5:0]  b;
        int          idx;
        for (int s = 0; s < 8; s++) begin
            b   = x[6*s+1 +: 6];
            idx = 16 * int'({b[5], b[0]}) + int'(b[4:1]);
            o[4*s+1 +: 4] = SBOX[s][255 - 4*idx -: 4];
        end
        return o;
    endfunction

    function automatic logic [1:56] f_pc1(input logic [1:64] k);
        logic [1:56] o;
        for (int i = 1; i <= 56; i++) o[i] = k[PC1[i-1]];
        return o;
    endfunction

    function automatic logic [1:48] f_pc2(input logic [1:56] cd);
        logic [1:48] o;
        for (int i = 1; i <= 48; i++) o[i] = cd[PC2[i-1]];
        return o;
    endfunction

    state_e         state_q, state_d;
    logic [1:32]    l_q, l_d, r_q, r_d;
    logic [1:28]    c_q, c_d, d_q, d_d;
    logic           dec_q, dec_d, ov_q, ov_d;
    logic [CW-1:0]  rnd_q, rnd_d;
    logic [1:64]    out_q, out_d;
    logic [1:56]    cd0;
    logic [1:32]    l_nx, r_nx;
    logic           accept;
    int             amt;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = ov_q;
    assign out_block = out_q;
    assign busy      = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        ov_d    = ov_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        cd0     = f_pc1(in_key);
        l_nx    = r_q;
        r_nx    = l_q ^ f_perm(f_sbox(f_expand(r_q) ^ f_pc2({c_q, d_q})));
        amt     = dec_q ? shift_of(ROUNDS + 1 - int'(rnd_q)) : shift_of(int'(rnd_q) + 1);

        case (state_q)
            RUN: begin
                l_d = l_nx;
                r_d = r_nx;
                if (rnd_q == RND_LAST) begin
                    out_d   = SWAP_FINAL ? {r_nx, l_nx} : {l_nx, r_nx};
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + CW'(1);
                    c_d   = key_step(c_q, dec_q, amt);
                    d_d   = key_step(d_q, dec_q, amt);
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Decrypt starts from the last round key, so preload C/D rotated by the full schedule sum.
        if (accept) begin
            l_d     = in_block[1:32];
            r_d     = in_block[33:64];
            dec_d   = in_decrypt;
            rnd_d   = CW'(1);
            c_d     = in_decrypt ? rotl(cd0[1:28], DEC_ROT)  : rotl(cd0[1:28], 1);
            d_d     = in_decrypt ? rotl(cd0[29:56], DEC_ROT) : rotl(cd0[29:56], 1);
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            ov_q    <= 1'b0;
            rnd_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            ov_q    <= ov_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
        end
    end
endmodule
